// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: per-frame scheduler for the scrolling obstacle sprites.
// Each accepted frame tick runs one pass: MOVE walks the slots one per cycle,
// scrolling live obstacles left and retiring those that have left the screen,
// then SPAWN accumulates the scrolled distance and places a new obstacle in the
// lowest free slot once the randomised gap has been covered.
//
// Ports:
//   clk            pixel clock
//   reset          synchronous active-high restart; aborts any pass
//   halt_i         collision latch; new passes are not started while high
//   frame_tick_i   one-cycle pulse per video frame
//   random_i       free-running RNG value (gap jitter and sprite type)
//   obj_valid_o    per-slot live flag
//   obj_x_o        per-slot right-edge x, slot i at bits [11i+10:11i]
//   obj_type_o     per-slot sprite type (0..2), slot i at bits [2i+1:2i]
//   speed_o        current scroll speed
//   spawn_count_o  spawns since reset, wraps at 255
//   busy_o         pass in progress; outputs are only stable while low
//   overrun_o      sticky: a frame tick arrived during a pass
//
// Build option: define SPEEDUP_EN to raise the speed by one every
// SPEEDUP_SPAN spawns, up to MAX_SPEED.

module obstacle_scheduler #(
    parameter int unsigned NSLOT        = 3,
    parameter int unsigned SCREEN_W     = 640,
    parameter int unsigned SPRITE_W     = 27,
    parameter int unsigned SPEED        = 2,
    parameter int unsigned MIN_GAP      = 250,
    parameter int unsigned SPEEDUP_SPAN = 8,
    parameter int unsigned MAX_SPEED    = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 halt_i,
    input  logic                 frame_tick_i,
    input  logic [4:0]           random_i,
    output logic [NSLOT-1:0]     obj_valid_o,
    output logic [11*NSLOT-1:0]  obj_x_o,
    output logic [2*NSLOT-1:0]   obj_type_o,
    output logic [3:0]           speed_o,
    output logic [7:0]           spawn_count_o,
    output logic                 busy_o,
    output logic                 overrun_o
);

    localparam int unsigned XW      = 11;
    localparam int unsigned IDXW    = $clog2(NSLOT);
    localparam int unsigned SPAWN_X = SCREEN_W + SPRITE_W;

    // Elaboration-time parameter range checks
    if (NSLOT < 2 || NSLOT > 8 || SPEED < 1 || SPEED > 15 ||
        MAX_SPEED > 15 || SPEEDUP_SPAN == 0) begin : g_bad_param
        $error("obstacle_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_t;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [NSLOT-1:0]  valid_q;
    logic [XW-1:0]     x_q    [NSLOT];
    logic [1:0]        type_q [NSLOT];
    logic [XW-1:0]     gap_q;
    logic [XW-1:0]     thr_q;
    logic [3:0]        speed_q;
    logic [7:0]        cnt_q;
    logic              busy_q;
    logic              overrun_q;

    logic [XW:0]       gap_sum_d;
    logic [XW-1:0]     gap_next_d;
    logic [XW-1:0]     thr_new_d;
    logic [1:0]        spawn_type_d;
    logic              free_found_d;
    logic [IDXW-1:0]   free_idx_d;

    // Scrolled distance since the last spawn, saturating at the 11-bit max
    assign gap_sum_d  = {1'b0, gap_q} + (XW+1)'(speed_q);
    assign gap_next_d = gap_sum_d[XW] ? {XW{1'b1}} : gap_sum_d[XW-1:0];

    // Next gap is MIN_GAP plus 0..7 steps of 32 pixels
    assign thr_new_d    = XW'(MIN_GAP) + XW'({random_i[4:2], 5'd0});
    // Only three sprite types exist; fold code 3 onto type 0
    assign spawn_type_d = (random_i[1:0] == 2'd3) ? 2'd0 : random_i[1:0];

    // Lowest-index free slot
    always_comb begin
        free_found_d = 1'b0;
        free_idx_d   = '0;
        for (int i = int'(NSLOT) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found_d = 1'b1;
                free_idx_d   = IDXW'(i);
            end
        end
    end

`ifdef SPEEDUP_EN
    logic [7:0] cnt_inc_d;
    assign cnt_inc_d = cnt_q + 8'd1;
`endif

    // Scheduler FSM and slot state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            valid_q   <= '0;
            for (int i = 0; i < int'(NSLOT); i++) begin
                x_q[i]    <= '0;
                type_q[i] <= '0;
            end
            gap_q     <= '0;
            thr_q     <= XW'(MIN_GAP);
            speed_q   <= 4'(SPEED);
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_tick_i && !halt_i) begin
                        state_q <= MOVE;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                MOVE: begin
                    if (frame_tick_i) overrun_q <= 1'b1;
                    for (int i = 0; i < int'(NSLOT); i++) begin
                        if (idx_q == IDXW'(i) && valid_q[i]) begin
                            // Retire keeps x so the last position stays readable
                            if (x_q[i] <= XW'(speed_q)) valid_q[i] <= 1'b0;
                            else                        x_q[i]     <= x_q[i] - XW'(speed_q);
                        end
                    end
                    if (idx_q == IDXW'(NSLOT - 1)) state_q <= SPAWN;
                    else                           idx_q   <= idx_q + IDXW'(1);
                end
                SPAWN: begin
                    if (frame_tick_i) overrun_q <= 1'b1;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (gap_next_d >= thr_q && free_found_d) begin
                        for (int i = 0; i < int'(NSLOT); i++) begin
                            if (free_idx_d == IDXW'(i)) begin
                                valid_q[i] <= 1'b1;
                                x_q[i]     <= XW'(SPAWN_X);
                                type_q[i]  <= spawn_type_d;
                            end
                        end
                        gap_q <= '0;
                        thr_q <= thr_new_d;
                        cnt_q <= cnt_q + 8'd1;
`ifdef SPEEDUP_EN
                        if ((cnt_inc_d % 8'(SPEEDUP_SPAN)) == 8'd0 && speed_q < 4'(MAX_SPEED))
                            speed_q <= speed_q + 4'd1;
`endif
                    end else begin
                        gap_q <= gap_next_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pack slot registers onto the renderer-facing buses
    for (genvar g = 0; g < int'(NSLOT); g++) begin : g_out
        assign obj_x_o[XW*g +: XW]  = x_q[g];
        assign obj_type_o[2*g +: 2] = type_q[g];
    end

    assign obj_valid_o   = valid_q;
    assign speed_o       = speed_q;
    assign spawn_count_o = cnt_q;
    assign busy_o        = busy_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: two instances (default gap and MIN_GAP=4)
// driven by shared directed stimulus; a frame-level model predicts every
// output, and literal expectations pin the key points of the scenario.

module tb_obstacle_scheduler;

    localparam int unsigned NSLOT = 3;
    localparam int SPAWN_X = 640 + 27;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, halt, frame_tick;
    logic [4:0] random;

    logic [NSLOT-1:0]    valid_a, valid_b;
    logic [11*NSLOT-1:0] x_a, x_b;
    logic [2*NSLOT-1:0]  type_a, type_b;
    logic [3:0]          speed_a, speed_b;
    logic [7:0]          cnt_a, cnt_b;
    logic                busy_a, busy_b, ovr_a, ovr_b;

    obstacle_scheduler #(.NSLOT(NSLOT)) dut_a (
        .clk(clk), .reset(reset), .halt_i(halt), .frame_tick_i(frame_tick),
        .random_i(random), .obj_valid_o(valid_a), .obj_x_o(x_a),
        .obj_type_o(type_a), .speed_o(speed_a), .spawn_count_o(cnt_a),
        .busy_o(busy_a), .overrun_o(ovr_a)
    );

    obstacle_scheduler #(.NSLOT(NSLOT), .MIN_GAP(4)) dut_b (
        .clk(clk), .reset(reset), .halt_i(halt), .frame_tick_i(frame_tick),
        .random_i(random), .obj_valid_o(valid_b), .obj_x_o(x_b),
        .obj_type_o(type_b), .speed_o(speed_b), .spawn_count_o(cnt_b),
        .busy_o(busy_b), .overrun_o(ovr_b)
    );

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a whole pass is applied at the accepting clock edge
    int m_valid [2][NSLOT];
    int m_x     [2][NSLOT];
    int m_type  [2][NSLOT];
    int m_gap   [2];
    int m_thr   [2];
    int m_speed [2];
    int m_cnt   [2];
    int m_ovr   [2];
    int m_min_gap [2] = '{250, 4};
    int busy_left = 0;

    task automatic model_pass(input int k);
        int free_slot;
        for (int i = 0; i < int'(NSLOT); i++) begin
            if (m_valid[k][i] != 0) begin
                if (m_x[k][i] <= m_speed[k]) m_valid[k][i] = 0;
                else                         m_x[k][i] = m_x[k][i] - m_speed[k];
            end
        end
        m_gap[k] = m_gap[k] + m_speed[k];
        if (m_gap[k] > 2047) m_gap[k] = 2047;
        free_slot = -1;
        for (int i = 0; i < int'(NSLOT); i++)
            if (m_valid[k][i] == 0 && free_slot < 0) free_slot = i;
        if (m_gap[k] >= m_thr[k] && free_slot >= 0) begin
            m_valid[k][free_slot] = 1;
            m_x[k][free_slot]     = SPAWN_X;
            m_type[k][free_slot]  = (int'(random) % 4 == 3) ? 0 : int'(random) % 4;
            m_gap[k] = 0;
            m_thr[k] = m_min_gap[k] + (int'(random) / 4) * 32;
            m_cnt[k] = (m_cnt[k] + 1) % 256;
`ifdef SPEEDUP_EN
            if (m_cnt[k] % 8 == 0 && m_speed[k] < 6) m_speed[k] = m_speed[k] + 1;
`endif
        end
    endtask

    task automatic model_step();
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < int'(NSLOT); i++) begin
                    m_valid[k][i] = 0; m_x[k][i] = 0; m_type[k][i] = 0;
                end
                m_gap[k] = 0; m_thr[k] = m_min_gap[k]; m_speed[k] = 2;
                m_cnt[k] = 0; m_ovr[k] = 0;
            end
            busy_left = 0;
        end else if (busy_left > 0) begin
            if (frame_tick) begin m_ovr[0] = 1; m_ovr[1] = 1; end
            busy_left--;
        end else if (frame_tick && !halt) begin
            model_pass(0);
            model_pass(1);
            busy_left = NSLOT + 1;
        end
    endtask

    always @(posedge clk) model_step();

    task automatic cmp_inst(input int k, input logic [NSLOT-1:0] v, input logic [11*NSLOT-1:0] x,
                            input logic [2*NSLOT-1:0] t, input logic [3:0] sp,
                            input logic [7:0] cnt, input logic ovr, input logic busy);
        string p;
        p = (k == 0) ? "a" : "b";
        check({p, ".busy"}, 32'(busy), 32'(busy_left > 0));
        if (busy_left == 0) begin
            for (int i = 0; i < int'(NSLOT); i++) begin
                check($sformatf("%s.valid%0d", p, i), 32'(v[i]), m_valid[k][i]);
                check($sformatf("%s.x%0d", p, i), 32'(x[11*i +: 11]), m_x[k][i]);
                check($sformatf("%s.type%0d", p, i), 32'(t[2*i +: 2]), m_type[k][i]);
            end
            check({p, ".speed"}, 32'(sp), m_speed[k]);
            check({p, ".count"}, 32'(cnt), m_cnt[k]);
            check({p, ".overrun"}, 32'(ovr), m_ovr[k]);
        end
    endtask

    // Model comparison on every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, valid_a, x_a, type_a, speed_a, cnt_a, ovr_a, busy_a);
            cmp_inst(1, valid_b, x_b, type_b, speed_b, cnt_b, ovr_b, busy_b);
        end
    end

    // One frame tick; returns how many cycles busy stayed high
    task automatic do_tick(output int blen);
        int n;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        blen = 0; n = 0;
        while (busy_a === 1'b1 && n < 20) begin
            blen++; n++;
            @(negedge clk);
        end
        if (n >= 20) check("busy_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int blen;
        reset = 1'b1; halt = 1'b0; frame_tick = 1'b0; random = 5'b00001;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst.valid", 32'(valid_a), 32'd0);
        check("rst.x", 32'(x_a), 32'd0);
        check("rst.speed", 32'(speed_a), 32'd2);
        check("rst.count", 32'(cnt_a), 32'd0);
        check("rst.busy", 32'(busy_a), 32'd0);
        check("rst.overrun", 32'(ovr_a), 32'd0);
        reset = 1'b0;

        // First spawn exactly when 125 frames * 2 px reach the 250 px gap
        repeat (124) do_tick(blen);
        check("t124.valid", 32'(valid_a), 32'd0);
        do_tick(blen);
        check("t125.valid", 32'(valid_a), 32'b001);
        check("t125.x0", 32'(x_a[10:0]), 32'd667);
        check("t125.type0", 32'(type_a[1:0]), 32'd1);
        check("t125.count", 32'(cnt_a), 32'd1);

        for (int i = 0; i < 10; i++) begin
            do_tick(blen);
            check("pass_len", 32'(blen), 32'd4);
        end
        check("t135.x0", 32'(x_a[10:0]), 32'd647);

        // Halted: ticks ignored, no pass, state frozen
        halt = 1'b1;
        repeat (50) do_tick(blen);
        check("halt.pass_len", 32'(blen), 32'd0);
        check("halt.x0", 32'(x_a[10:0]), 32'd647);
        check("halt.count", 32'(cnt_a), 32'd1);
        halt = 1'b0;
        do_tick(blen);
        check("unhalt.x0", 32'(x_a[10:0]), 32'd645);

        // Tick one cycle after an accepted tick
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); blen = (busy_a === 1'b1) ? 1 : 0;
        @(negedge clk); frame_tick = 1'b0;
        for (int n = 0; n < 20 && busy_a === 1'b1; n++) begin
            blen++;
            @(negedge clk);
        end
        check("ovr.pass_len", 32'(blen), 32'd4);
        check("ovr.flag", 32'(ovr_a), 32'd1);
        check("ovr.count", 32'(cnt_a), 32'd1);

        reset = 1'b1; random = 5'b00011;
        repeat (2) @(negedge clk);
        check("rst2.overrun", 32'(ovr_a), 32'd0);
        check("rst2.valid", 32'(valid_a), 32'd0);
        reset = 1'b0;

        // Short-gap instance: spawns every second frame until full
        do_tick(blen); check("b.t1.valid", 32'(valid_b), 32'b000);
        do_tick(blen); check("b.t2.valid", 32'(valid_b), 32'b001);
        check("b.t2.type0", 32'(type_b[1:0]), 32'd0);
        do_tick(blen); do_tick(blen); check("b.t4.valid", 32'(valid_b), 32'b011);
        do_tick(blen); do_tick(blen); check("b.t6.valid", 32'(valid_b), 32'b111);
        check("b.t6.count", 32'(cnt_b), 32'd3);
        do_tick(blen); do_tick(blen); check("b.t8.valid", 32'(valid_b), 32'b111);
        check("b.t8.count", 32'(cnt_b), 32'd3);
        repeat (325) do_tick(blen);
        do_tick(blen); check("b.t334.x0", 32'(x_b[10:0]), 32'd3);
        do_tick(blen); check("b.t335.x0", 32'(x_b[10:0]), 32'd1);
        check("b.t335.count", 32'(cnt_b), 32'd3);
        // Slot 0 retires and takes the deferred spawn in the same pass
        random = 5'b11111;
        do_tick(blen);
        check("b.t336.valid", 32'(valid_b), 32'b111);
        check("b.t336.x0", 32'(x_b[10:0]), 32'd667);
        check("b.t336.type0", 32'(type_b[1:0]), 32'd0);
        check("b.t336.count", 32'(cnt_b), 32'd4);
        check("b.t336.x1", 32'(x_b[21:11]), 32'd3);
        do_tick(blen); check("b.t337.x1", 32'(x_b[21:11]), 32'd1);
        // New threshold 228 blocks respawn; retired slot keeps its x
        do_tick(blen);
        check("b.t338.valid", 32'(valid_b), 32'b101);
        check("b.t338.x1", 32'(x_b[21:11]), 32'd1);
        check("b.t338.count", 32'(cnt_b), 32'd4);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
